// File: rtl/fp_div_arbiter.sv
// Round-robin arbiter and sequencer sharing one FP div/sqrt unit between two issue ports.
// One op in flight; the in-flight tag is tracked through flushes and the result sits in a 1-entry buffer until the CDB takes it.
module fp_div_arbiter #(
  parameter int TAG_W      = 5,
  parameter int FLEN       = 64,
  parameter int MAX_CYCLES = 64
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [1:0]           i_req_valid,
  input  logic [2*TAG_W-1:0]   i_req_tag,
  input  logic [1:0]           i_req_is_sqrt,
  input  logic [1:0]           i_req_is_double,
  input  logic [5:0]           i_req_rm,
  input  logic [2*FLEN-1:0]    i_req_src1,
  input  logic [2*FLEN-1:0]    i_req_src2,
  output logic [1:0]           o_req_ready,
  output logic                 o_unit_start,
  output logic                 o_unit_is_sqrt,
  output logic                 o_unit_is_double,
  output logic [2:0]           o_unit_rm,
  output logic [FLEN-1:0]      o_unit_src1,
  output logic [FLEN-1:0]      o_unit_src2,
  input  logic                 i_unit_done,
  input  logic [FLEN-1:0]      i_unit_result,
  input  logic [4:0]           i_unit_flags,
  output logic                 o_res_valid,
  output logic [TAG_W-1:0]     o_res_tag,
  output logic                 o_res_req_id,
  output logic [FLEN-1:0]      o_res_value,
  output logic [4:0]           o_res_flags,
  input  logic                 i_res_ready,
  input  logic                 i_flush,
  input  logic                 i_flush_en,
  input  logic [TAG_W-1:0]     i_flush_tag,
  input  logic [TAG_W-1:0]     i_rob_head_tag,
  output logic                 o_busy,
  output logic                 o_timeout_err
);

  localparam int CNT_W = $clog2(MAX_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD} state_e;

  state_e            state_q, state_d;
  logic              rr_q, rr_d;
  logic              killed_q, killed_d;
  logic              timeout_q, timeout_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic              req_id_q, req_id_d;
  logic              dbl_q, dbl_d;
  logic [FLEN-1:0]   val_q, val_d;
  logic [4:0]        flags_q, flags_d;

  // Distance from the ROB head decides age; a tag equal to the flush boundary survives.
  function automatic logic younger(input logic [TAG_W-1:0] t,
                                   input logic [TAG_W-1:0] head,
                                   input logic [TAG_W-1:0] ftag);
    logic [TAG_W:0] dt;
    logic [TAG_W:0] df;
    dt = {1'b0, t} - {1'b0, head};
    df = {1'b0, ftag} - {1'b0, head};
    return dt > df;
  endfunction

  logic             cand;
  logic [TAG_W-1:0] cand_tag;
  logic             grant;
  logic             kill_cur;

  always_comb begin
    cand     = (&i_req_valid) ? rr_q : i_req_valid[1];
    cand_tag = cand ? i_req_tag[TAG_W +: TAG_W] : i_req_tag[0 +: TAG_W];
    grant    = (state_q == S_IDLE) && (|i_req_valid) &&
               !(i_flush || (i_flush_en && younger(cand_tag, i_rob_head_tag, i_flush_tag)));
    kill_cur = i_flush || (i_flush_en && younger(tag_q, i_rob_head_tag, i_flush_tag));
  end

  always_comb begin
    o_req_ready      = 2'b00;
    o_unit_start     = 1'b0;
    o_unit_is_sqrt   = 1'b0;
    o_unit_is_double = 1'b0;
    o_unit_rm        = 3'b000;
    o_unit_src1      = '0;
    o_unit_src2      = '0;
    if (grant) begin
      o_req_ready[cand] = 1'b1;
      o_unit_start      = 1'b1;
      o_unit_is_sqrt    = i_req_is_sqrt[cand];
      o_unit_is_double  = i_req_is_double[cand];
      o_unit_rm         = cand ? i_req_rm[5:3] : i_req_rm[2:0];
      o_unit_src1       = cand ? i_req_src1[FLEN +: FLEN] : i_req_src1[0 +: FLEN];
      o_unit_src2       = cand ? i_req_src2[FLEN +: FLEN] : i_req_src2[0 +: FLEN];
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    killed_d  = killed_q;
    timeout_d = timeout_q;
    cnt_d     = cnt_q;
    tag_d     = tag_q;
    req_id_d  = req_id_q;
    dbl_d     = dbl_q;
    val_d     = val_q;
    flags_d   = flags_q;
    case (state_q)
      S_IDLE: begin
        if (grant) begin
          tag_d    = cand_tag;
          req_id_d = cand;
          dbl_d    = i_req_is_double[cand];
          rr_d     = ~cand;
          killed_d = 1'b0;
          cnt_d    = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        cnt_d    = cnt_q + 1'b1;
        killed_d = killed_q | kill_cur;
        if (i_unit_done) begin
          killed_d = 1'b0;
          if (killed_q || kill_cur) begin
            state_d = S_IDLE;
          end else begin
            val_d   = dbl_q ? i_unit_result : {{(FLEN-32){1'b1}}, i_unit_result[31:0]};
            flags_d = i_unit_flags;
            state_d = S_HOLD;
          end
        end else if (cnt_d == CNT_W'(MAX_CYCLES)) begin
          // The unit cannot be aborted, so a hung op just frees the arbiter.
          timeout_d = 1'b1;
          killed_d  = 1'b0;
          state_d   = S_IDLE;
        end
      end
      S_HOLD: begin
        if (kill_cur || i_res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      rr_q      <= 1'b0;
      killed_q  <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
      tag_q     <= '0;
      req_id_q  <= 1'b0;
      dbl_q     <= 1'b0;
      val_q     <= '0;
      flags_q   <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      killed_q  <= killed_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
      tag_q     <= tag_d;
      req_id_q  <= req_id_d;
      dbl_q     <= dbl_d;
      val_q     <= val_d;
      flags_q   <= flags_d;
    end
  end

  assign o_res_valid   = (state_q == S_HOLD) && !kill_cur;
  assign o_res_tag     = tag_q;
  assign o_res_req_id  = req_id_q;
  assign o_res_value   = val_q;
  assign o_res_flags   = flags_q;
  assign o_busy        = (state_q != S_IDLE);
  assign o_timeout_err = timeout_q;

endmodule

// File: tb/tb_fp_div_arbiter.sv
// Directed bench for fp_div_arbiter: the bench plays the div/sqrt unit and the CDB consumer.
module tb_fp_div_arbiter;
  localparam int TAG_W = 5;
  localparam int FLEN  = 64;
  localparam int MAXC  = 64;

  logic               i_clk = 1'b0;
  logic               i_rst_n;
  logic [1:0]         i_req_valid;
  logic [2*TAG_W-1:0] i_req_tag;
  logic [1:0]         i_req_is_sqrt;
  logic [1:0]         i_req_is_double;
  logic [5:0]         i_req_rm;
  logic [2*FLEN-1:0]  i_req_src1;
  logic [2*FLEN-1:0]  i_req_src2;
  logic [1:0]         o_req_ready;
  logic               o_unit_start;
  logic               o_unit_is_sqrt;
  logic               o_unit_is_double;
  logic [2:0]         o_unit_rm;
  logic [FLEN-1:0]    o_unit_src1;
  logic [FLEN-1:0]    o_unit_src2;
  logic               i_unit_done;
  logic [FLEN-1:0]    i_unit_result;
  logic [4:0]         i_unit_flags;
  logic               o_res_valid;
  logic [TAG_W-1:0]   o_res_tag;
  logic               o_res_req_id;
  logic [FLEN-1:0]    o_res_value;
  logic [4:0]         o_res_flags;
  logic               i_res_ready;
  logic               i_flush;
  logic               i_flush_en;
  logic [TAG_W-1:0]   i_flush_tag;
  logic [TAG_W-1:0]   i_rob_head_tag;
  logic               o_busy;
  logic               o_timeout_err;

  always #5 i_clk = ~i_clk;

  fp_div_arbiter #(.TAG_W(TAG_W), .FLEN(FLEN), .MAX_CYCLES(MAXC)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_req_valid(i_req_valid), .i_req_tag(i_req_tag), .i_req_is_sqrt(i_req_is_sqrt),
    .i_req_is_double(i_req_is_double), .i_req_rm(i_req_rm),
    .i_req_src1(i_req_src1), .i_req_src2(i_req_src2), .o_req_ready(o_req_ready),
    .o_unit_start(o_unit_start), .o_unit_is_sqrt(o_unit_is_sqrt),
    .o_unit_is_double(o_unit_is_double), .o_unit_rm(o_unit_rm),
    .o_unit_src1(o_unit_src1), .o_unit_src2(o_unit_src2),
    .i_unit_done(i_unit_done), .i_unit_result(i_unit_result), .i_unit_flags(i_unit_flags),
    .o_res_valid(o_res_valid), .o_res_tag(o_res_tag), .o_res_req_id(o_res_req_id),
    .o_res_value(o_res_value), .o_res_flags(o_res_flags), .i_res_ready(i_res_ready),
    .i_flush(i_flush), .i_flush_en(i_flush_en), .i_flush_tag(i_flush_tag),
    .i_rob_head_tag(i_rob_head_tag), .o_busy(o_busy), .o_timeout_err(o_timeout_err)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    bit               id;
    logic [TAG_W-1:0] tag;
    bit               dbl;
    bit               sqrt;
    logic [2:0]       rm;
    logic [63:0]      s1;
    logic [63:0]      s2;
    logic [63:0]      res;
    logic [4:0]       flags;
    bit               full_flush;
    bit               part_flush;
    logic [TAG_W-1:0] head;
    logic [TAG_W-1:0] ftag;
    int               kill_cyc;
    bit               exp_deliver;
    logic [63:0]      exp_val;
  } op_t;

  op_t tab[7];

  task automatic clr_all();
    i_req_valid = '0; i_req_tag = '0; i_req_is_sqrt = '0; i_req_is_double = '0;
    i_req_rm = '0; i_req_src1 = '0; i_req_src2 = '0;
    i_unit_done = 1'b0; i_unit_result = '0; i_unit_flags = '0;
    i_res_ready = 1'b0; i_flush = 1'b0; i_flush_en = 1'b0;
    i_flush_tag = '0; i_rob_head_tag = '0;
  endtask

  task automatic set_req(input bit id, input logic [TAG_W-1:0] tag, input bit sqrt,
                         input bit dbl, input logic [2:0] rm,
                         input logic [63:0] s1, input logic [63:0] s2);
    i_req_valid[id]               = 1'b1;
    i_req_tag[id*TAG_W +: TAG_W]  = tag;
    i_req_is_sqrt[id]             = sqrt;
    i_req_is_double[id]           = dbl;
    i_req_rm[id*3 +: 3]           = rm;
    i_req_src1[id*FLEN +: FLEN]   = s1;
    i_req_src2[id*FLEN +: FLEN]   = s2;
  endtask

  // Unit answers 30 cycles after accept; optional flush pulse at RUN cycle kill_cyc.
  task automatic run_op(input op_t o, input int idx);
    @(negedge i_clk);
    clr_all();
    set_req(o.id, o.tag, o.sqrt, o.dbl, o.rm, o.s1, o.s2);
    i_rob_head_tag = o.head;
    i_flush_tag    = o.ftag;
    #1;
    chk($sformatf("op%0d_grant", idx), o_req_ready, o.id ? 2'b10 : 2'b01);
    chk($sformatf("op%0d_start", idx), o_unit_start, 1);
    chk($sformatf("op%0d_src1", idx), o_unit_src1, o.s1);
    chk($sformatf("op%0d_src2", idx), o_unit_src2, o.s2);
    chk($sformatf("op%0d_dbl", idx), o_unit_is_double, o.dbl);
    chk($sformatf("op%0d_rm", idx), o_unit_rm, o.rm);
    for (int k = 1; k <= 30; k++) begin
      @(negedge i_clk);
      i_req_valid = '0; i_flush = 1'b0; i_flush_en = 1'b0; i_unit_done = 1'b0;
      if (k == o.kill_cyc) begin
        i_flush = o.full_flush; i_flush_en = o.part_flush;
      end
      if (k == 30) begin
        i_unit_done = 1'b1; i_unit_result = o.res; i_unit_flags = o.flags;
      end
      #1;
      if (k == 2) begin
        chk($sformatf("op%0d_busy", idx), o_busy, 1);
        chk($sformatf("op%0d_no_regrant", idx), {o_req_ready, o_unit_start}, 0);
      end
    end
    @(negedge i_clk);
    i_unit_done = 1'b0; i_flush = 1'b0; i_flush_en = 1'b0; i_unit_result = '0;
    #1;
    chk($sformatf("op%0d_res_valid", idx), o_res_valid, o.exp_deliver);
    if (o.exp_deliver) begin
      chk($sformatf("op%0d_value", idx), o_res_value, o.exp_val);
      chk($sformatf("op%0d_tag", idx), o_res_tag, o.tag);
      chk($sformatf("op%0d_req_id", idx), o_res_req_id, o.id);
      chk($sformatf("op%0d_flags", idx), o_res_flags, o.flags);
      repeat (2) @(negedge i_clk);
      #1 chk($sformatf("op%0d_held", idx), o_res_valid, 1);
      @(negedge i_clk); i_res_ready = 1'b1;
      @(negedge i_clk); i_res_ready = 1'b0;
    end
    #1 chk($sformatf("op%0d_idle_after", idx), {o_busy, o_res_valid}, 0);
  endtask

  // Short op on an already-granted requester: done at RUN cycle 3, consumed in HOLD.
  task automatic finish_short(input bit id, input string nm);
    for (int k = 1; k <= 3; k++) begin
      @(negedge i_clk);
      i_req_valid = '0; i_flush_en = 1'b0;
      i_unit_done = (k == 3); i_unit_result = 64'h0000_0000_3F80_0000;
    end
    @(negedge i_clk);
    i_unit_done = 1'b0; i_res_ready = 1'b1;
    #1 chk({nm, "_valid"}, o_res_valid, 1);
    chk({nm, "_req_id"}, o_res_req_id, id);
    @(negedge i_clk);
    i_res_ready = 1'b0;
    #1 chk({nm, "_idle"}, o_busy, 0);
  endtask

  initial begin
    //       id tag  dbl sqrt rm    src1                    src2                    result                  flags     ff pf head ftag kc  dlv exp_val
    tab[0] = '{0, 3, 0, 0, 3'd0, 64'h0000_0000_40C0_0000, 64'h0000_0000_4000_0000, 64'h0000_0000_4040_0000, 5'b00000, 0, 0, 0, 0, 0, 1, 64'hFFFF_FFFF_4040_0000};
    tab[1] = '{1, 9, 1, 0, 3'd1, 64'h4018_0000_0000_0000, 64'h4000_0000_0000_0000, 64'h4008_0000_0000_0000, 5'b00001, 0, 0, 0, 0, 0, 1, 64'h4008_0000_0000_0000};
    tab[2] = '{0, 7, 0, 0, 3'd0, 64'h0000_0000_4120_0000, 64'h0000_0000_4000_0000, 64'h0000_0000_40A0_0000, 5'b00000, 0, 1, 2, 5, 5, 0, 64'h0};
    tab[3] = '{1, 4, 0, 1, 3'd2, 64'h0000_0000_3F80_0000, 64'h0, 64'hDEAD_BEEF_3F80_0000, 5'b00001, 0, 1, 2, 5, 5, 1, 64'hFFFF_FFFF_3F80_0000};
    tab[4] = '{0, 5, 1, 1, 3'd4, 64'h4010_0000_0000_0000, 64'h0, 64'h4000_0000_0000_0000, 5'b10000, 0, 1, 2, 5, 12, 1, 64'h4000_0000_0000_0000};
    tab[5] = '{1, 1, 1, 0, 3'd0, 64'h3FF0_0000_0000_0000, 64'h0, 64'h7FF0_0000_0000_0000, 5'b01000, 1, 0, 0, 0, 10, 0, 64'h0};
    tab[6] = '{0, 7, 0, 0, 3'd0, 64'h0000_0000_4000_0000, 64'h0000_0000_4000_0000, 64'h0000_0000_3F80_0000, 5'b00000, 0, 1, 2, 5, 30, 0, 64'h0};

    clr_all();
    i_rst_n = 1'b0;
    repeat (2) @(negedge i_clk);
    #1;
    chk("rst_ready", o_req_ready, 0);
    chk("rst_start", o_unit_start, 0);
    chk("rst_res_valid", o_res_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_timeout", o_timeout_err, 0);
    chk("rst_res_value", o_res_value, 0);
    chk("rst_unit_src1", o_unit_src1, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // Stray done in IDLE must not create a result.
    @(negedge i_clk); i_unit_done = 1'b1; i_unit_result = 64'h1234;
    @(negedge i_clk); i_unit_done = 1'b0;
    #1 chk("stray_done_idle", {o_busy, o_res_valid}, 0);

    // Both requesters held valid: grants must alternate 0,1,0,1 starting from pointer 0.
    @(negedge i_clk);
    set_req(0, 5'd1, 0, 1, 3'd0, 64'hA0, 64'hA1);
    set_req(1, 5'd2, 0, 1, 3'd0, 64'hB0, 64'hB1);
    for (int g = 0; g < 4; g++) begin
      #1 chk($sformatf("alt_grant%0d", g), o_req_ready, (g % 2) ? 2'b10 : 2'b01);
      for (int k = 1; k <= 4; k++) begin
        @(negedge i_clk);
        i_unit_done = (k == 3); i_res_ready = (k == 4);
        #1 chk($sformatf("alt_busy_noready%0d_%0d", g, k), {o_req_ready, o_unit_start}, 0);
        if (k == 4) chk($sformatf("alt_res_id%0d", g), {o_res_valid, o_res_req_id}, {1'b1, g[0]});
      end
      @(negedge i_clk);
      i_unit_done = 1'b0; i_res_ready = 1'b0;
      if (g == 3) i_req_valid = '0;
    end

    // Flush in the grant cycle: candidate req0 (tag 6) is younger than boundary 5.
    clr_all();
    set_req(0, 5'd6, 0, 0, 3'd0, 64'hC0, 64'hC1);
    set_req(1, 5'd3, 0, 0, 3'd0, 64'hD0, 64'hD1);
    i_rob_head_tag = 5'd2; i_flush_tag = 5'd5; i_flush_en = 1'b1;
    #1 chk("gflush_ready", o_req_ready, 0);
    chk("gflush_start", o_unit_start, 0);
    chk("gflush_src1", o_unit_src1, 0);
    @(negedge i_clk);
    i_req_valid = 2'b10; i_flush_en = 1'b0;
    #1 chk("gflush_next_ready", o_req_ready, 2'b10);
    chk("gflush_next_src1", o_unit_src1, 64'hD0);
    finish_short(1'b1, "gflush_op");

    // Result parked in HOLD for 10 cycles, then a full flush drops it.
    @(negedge i_clk);
    clr_all();
    set_req(0, 5'd3, 0, 0, 3'd0, 64'hE0, 64'hE1);
    #1 chk("hflush_grant", o_req_ready, 2'b01);
    for (int k = 1; k <= 3; k++) begin
      @(negedge i_clk);
      i_req_valid = '0; i_unit_done = (k == 3);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge i_clk);
      i_unit_done = 1'b0;
      #1 chk($sformatf("hflush_hold%0d", k), o_res_valid, 1);
    end
    @(negedge i_clk);
    i_flush = 1'b1;
    #1 chk("hflush_valid_drop", o_res_valid, 0);
    @(negedge i_clk);
    i_flush = 1'b0;
    #1 chk("hflush_idle", o_busy, 0);

    for (int i = 0; i < 7; i++) run_op(tab[i], i);

    // Watchdog: done withheld; error and IDLE after the 64th RUN cycle.
    @(negedge i_clk);
    clr_all();
    set_req(1, 5'd8, 0, 1, 3'd0, 64'hF0, 64'hF1);
    #1 chk("wd_grant", o_req_ready, 2'b10);
    for (int k = 1; k <= 64; k++) begin
      @(negedge i_clk);
      i_req_valid = '0;
      #1 if (k == 63 || k == 64) chk($sformatf("wd_run%0d", k), {o_busy, o_timeout_err}, 2'b10);
    end
    @(negedge i_clk);
    #1 chk("wd_fired", {o_busy, o_timeout_err}, 2'b01);
    run_op(tab[0], 10);
    chk("wd_sticky", o_timeout_err, 1);

    // Reset in the middle of an op clears everything at once.
    @(negedge i_clk);
    set_req(0, 5'd2, 0, 0, 3'd0, 64'h11, 64'h22);
    @(negedge i_clk);
    i_req_valid = '0;
    #1 chk("mid_rst_busy_before", o_busy, 1);
    i_rst_n = 1'b0;
    #1 chk("mid_rst_state", {o_busy, o_timeout_err, o_res_valid}, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL tb_timeout actual=running required=finished");
    $fatal(1, "bench time limit");
  end

endmodule

// File: doc/fp_div_arbiter.md
Name: fp_div_arbiter

Overview:
- Shares one fpu_div_sqrt_unit between two issue requesters (req 0 and req 1, e.g. two FP reservation-station issue ports).
- Arbitrates round-robin and sequences the unit: one operation in flight at a time.
- Tracks the in-flight ROB tag through full and partial pipeline flushes.
- Holds each completed result in a 1-entry buffer until the CDB adapter accepts it.

Parameters:
TAG_W, riscv_pkg::ReorderBufferTagWidth, ROB tag width
FLEN, 64, operand/result width
MAX_CYCLES, 64, RUN-state watchdog limit in cycles (≥ worst-case unit latency + margin)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  reset, asynchronous, active-low
i_req_valid  in  2  per-requester request valid
i_req_tag  in  2*TAG_W  per-requester ROB tag; req n at [n*TAG_W +: TAG_W]
i_req_is_sqrt  in  2  1 = FSQRT, 0 = FDIV
i_req_is_double  in  2  1 = D, 0 = S
i_req_rm  in  2*3  rounding mode
i_req_src1  in  2*FLEN  operand a
i_req_src2  in  2*FLEN  operand b; ignored for sqrt
o_req_ready  out  2  one-hot grant, same cycle as accept
o_unit_start  out  1  single-cycle start pulse to unit
o_unit_is_sqrt  out  1  muxed op bit
o_unit_is_double  out  1  muxed op bit
o_unit_rm  out  3  muxed rounding mode
o_unit_src1  out  FLEN  muxed operand
o_unit_src2  out  FLEN  muxed operand
i_unit_done  in  1  unit result valid (div_valid | sqrt_valid)
i_unit_result  in  FLEN  unit result, already selected div/sqrt
i_unit_flags  in  5  fflags NV/DZ/OF/UF/NX
o_res_valid  out  1  buffered result valid
o_res_tag  out  TAG_W  ROB tag of result
o_res_req_id  out  1  requester that issued it
o_res_value  out  FLEN  result; S results NaN-boxed
o_res_flags  out  5  fflags
i_res_ready  in  1  consumer accepts result
i_flush  in  1  full flush
i_flush_en  in  1  partial flush
i_flush_tag  in  TAG_W  partial-flush boundary tag
i_rob_head_tag  in  TAG_W  ROB head for age compare
o_busy  out  1  state != IDLE
o_timeout_err  out  1  sticky watchdog error

Behaviour:
- Reset: state IDLE, rr pointer 0, killed 0, watchdog count 0, o_timeout_err 0. All outputs 0.
- Age: younger(t) = (t − head) > (flush_tag − head), computed on TAG_W+1 bits zero-extended. Equal to the flush tag is not killed.
- IDLE:
  - Candidate = valid requester. If both are valid, the candidate is the rr pointer.
  - Grant is suppressed if i_flush, or if i_flush_en and younger(candidate tag). The other requester is not tried that cycle.
  - On grant: o_req_ready[c] = 1 and o_unit_start = 1 in the same cycle. o_unit_* carry requester c's fields combinationally.
  - Latch tag, req id, is_double. Set rr pointer = ~c. Go to RUN.
  - With no grant, o_unit_* = 0.
- RUN:
  - Watchdog count increments each cycle.
  - i_flush, or i_flush_en with younger(latched tag), sets killed. The unit cannot be aborted.
  - On i_unit_done:
    - If killed, or a kill condition is true this cycle: discard, clear killed, go to IDLE.
    - Otherwise capture into the buffer and go to HOLD.
  - If count reaches MAX_CYCLES without done: set o_timeout_err, clear killed, go to IDLE.
- HOLD:
  - o_res_valid = 1, except forced 0 in any cycle with i_flush, or i_flush_en with younger(buffered tag).
  - In such a flush cycle, drop the buffer and go to IDLE.
  - Otherwise, when i_res_ready is high, go to IDLE.
  - No new grant is made in HOLD. The earliest next grant is the cycle after IDLE is re-entered.
- Stray i_unit_done in IDLE or HOLD is ignored.
- Result formatting:
  - is_double = 0: value = {32'hFFFF_FFFF, result[31:0]}.
  - is_double = 1: value = result.
  - Flags pass through unchanged.
- Latency: accept at T → o_res_valid at T_done+1. One accepted op per (unit latency + 2) cycles minimum.
- Reset asserted mid-operation returns to IDLE immediately. The unit is reset on the same reset.

Test Plan:
- Req0 FDIV_S, src1=0x40C00000, src2=0x40000000 (6.0/2.0), unit done 30 cycles later with 0x40400000 → o_res_value=0xFFFFFFFF40400000, tag matches, req_id=0, flags=0, held until i_res_ready.
- Both requesters valid continuously, pointer 0 → grants alternate 0,1,0,1. No grant is issued while busy.
- Partial flush, head=2, flush_tag=5: in RUN with tag 7 → result discarded, o_res_valid never asserts. Same sequence with tag 4 → result delivered.
- Flush in grant cycle: req0 tag 6 younger → o_req_ready=00, no o_unit_start. Req1 is granted the next cycle if not killed.
- HOLD with i_res_ready=0 for 10 cycles, then i_flush → o_res_valid drops that cycle, back to IDLE. A subsequent request is served normally.
- i_unit_done withheld with MAX_CYCLES=64 → o_timeout_err=1 at cycle 64 of RUN, state IDLE. Error stays set until reset.
